cordic_sincos_arbiter: RTL
==========================

CORDIC_SINCOS_ARBITER -- requirements
Module: cordic_sincos_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, meaning number of requesters (2..8).
REQ-002 SHALL have parameter TIMEOUT, default 64, meaning maximum cycles to wait for core result after start.
REQ-003 SHALL have port clk  input  1  the single clock; all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port en  input  1  when low, no new grants are issued; an in-flight operation completes.
REQ-006 SHALL have port req_valid  input  NUM_REQ  per-requester request.
REQ-007 SHALL have port req_angle  input  32*NUM_REQ  packed angles, slice i = [32*i+31:32*i], format 2^32*theta/(2*pi).
REQ-008 SHALL have port req_ready  output  NUM_REQ  one-hot, one-cycle accept pulse.
REQ-009 SHALL have port rsp_valid  output  1  one-cycle result pulse.
REQ-010 SHALL have port rsp_id  output  3  index of the requester that owns the result.
REQ-011 SHALL have port rsp_sine / rsp_cosine  output  16 each  signed result.
REQ-012 SHALL have port rsp_timeout  output  1  qualifies rsp_valid; high means the core did not answer.
REQ-013 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-014 SHALL have ports core_enable, core_start (output 1), core_angle (output 32), core_sine, core_cosine (input 16 signed), core_valid (input 1), wired to one cordic_sincos instance.

Function
REQ-015 SHALL use FSM states IDLE, ISSUE, WAIT, RESP.
REQ-016 IDLE: if en=1 and any req_valid, SHALL grant round-robin starting at index ptr, assert req_ready[g] that cycle, latch angle and g, go to ISSUE; otherwise stay.
REQ-017 ISSUE: SHALL assert core_start for exactly one cycle with core_angle = latched angle, clear timeout counter, go to WAIT.
REQ-018 WAIT: SHALL detect core_valid rising edge (core_valid=1, previous-cycle core_valid=0), capture core_sine/core_cosine, go to RESP.
REQ-019 WAIT: SHALL count cycles; on reaching TIMEOUT-1 without an edge, capture zero data, set timeout flag, go to RESP.
REQ-020 Simultaneous edge and timeout in the same cycle SHALL be treated as a valid result (timeout flag low).
REQ-021 RESP: SHALL assert rsp_valid one cycle with rsp_id, data and rsp_timeout; set ptr = (g+1) mod NUM_REQ; go to IDLE.
REQ-022 rsp_id/rsp_sine/rsp_cosine/rsp_timeout SHALL hold their values until the next RESP.
REQ-023 req_valid dropping after grant SHALL NOT affect the in-flight operation; no request is accepted outside IDLE.
REQ-024 Requester index NUM_REQ-1 SHALL wrap to 0 in ptr arithmetic.
REQ-025 core_enable SHALL be 1 in every cycle out of reset.
REQ-026 Minimum accept-to-rsp_valid latency SHALL be core latency + 3 cycles; back-to-back grants SHALL be separated by at least one IDLE cycle.

Reset
REQ-027 With rst_n=0 at a clock edge: state=IDLE, ptr=0, req_ready=0, core_start=0, core_enable=0, core_angle=0, rsp_valid=0, rsp_id=0, rsp_sine=0, rsp_cosine=0, rsp_timeout=0, busy=0, counters and edge register cleared.
REQ-028 Reset asserted mid-operation SHALL abandon it with no rsp_valid; a late core_valid after reset SHALL be ignored unless a start was issued.

Structure
REQ-029 Shared package cordic_pkg SHALL hold ANGLE_W=32, DATA_W=16 and the FSM state encoding.
REQ-030 Round-robin grant logic SHALL be a sub-module rr_arbiter (inputs req, ptr; output one-hot grant).

Verification
REQ-031 Single request: req_valid=4'b0001, angle 32'h20000000 -> one req_ready[0] pulse, one core_start, rsp_valid with rsp_id=0, sine≈cosine≈+23170 (±16).
REQ-032 All four requesting continuously -> grants in order 0,1,2,3,0; each rsp_id matches the grant.
REQ-033 Fairness after ptr=2: req_valid=4'b0101 -> grant 2 then 0.
REQ-034 Core stub never asserts core_valid -> rsp_valid with rsp_timeout=1, sine=cosine=0, exactly TIMEOUT cycles after core_start.
REQ-035 rst_n=0 during WAIT -> all outputs at reset values next cycle, no rsp_valid, next request granted from index 0.
REQ-036 en=0 with req_valid=4'b1111 -> no req_ready, busy=0; an operation already in WAIT still completes.

Source files
------------

// File: rtl/cordic_pkg.sv
// Shared widths and FSM encoding for the CORDIC sine/cosine request arbiter
// and its round-robin grant logic.
package cordic_pkg;

  localparam int ANGLE_W = 32;
  localparam int DATA_W  = 16;
  localparam int IDX_W   = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_e;

  // Successor of a requester index, wrapping the last requester back to 0.
  function automatic logic [IDX_W-1:0] next_ptr(input logic [IDX_W-1:0] idx,
                                                 input int              num_req);
    if (idx == IDX_W'(num_req - 1)) begin
      return '0;
    end else begin
      return idx + IDX_W'(1);
    end
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: searches req starting at index ptr (wrapping at N)
// and returns a one-hot grant plus its binary index.
module rr_arbiter
  import cordic_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_any
);

  logic [7:0] req_ext_s;

  assign req_ext_s = 8'(req);

  // First requesting index at or after ptr, modulo N.
  always_comb begin
    logic [3:0] cand;
    cand      = 4'd0;
    grant_idx = '0;
    grant_any = 1'b0;
    for (int i = 0; i < N; i++) begin
      cand = {1'b0, ptr} + 4'(i);
      if (cand >= 4'(N)) begin
        cand = cand - 4'(N);
      end else begin
        cand = cand;
      end
      if (!grant_any && req_ext_s[cand[2:0]]) begin
        grant_idx = cand[2:0];
        grant_any = 1'b1;
      end else begin
        grant_any = grant_any;
      end
    end
  end

  always_comb begin
    grant = '0;
    for (int j = 0; j < N; j++) begin
      grant[j] = grant_any && (grant_idx == IDX_W'(j));
    end
  end

endmodule

// File: rtl/cordic_sincos_arbiter.sv
// Shares one external CORDIC sine/cosine core among NUM_REQ requesters with
// round-robin grants, a start/response handshake and a result timeout.
module cordic_sincos_arbiter
  import cordic_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        en,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [ANGLE_W*NUM_REQ-1:0]  req_angle,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic                        rsp_valid,
  output logic [IDX_W-1:0]            rsp_id,
  output logic signed [DATA_W-1:0]    rsp_sine,
  output logic signed [DATA_W-1:0]    rsp_cosine,
  output logic                        rsp_timeout,
  output logic                        busy,
  output logic                        core_enable,
  output logic                        core_start,
  output logic [ANGLE_W-1:0]          core_angle,
  input  logic signed [DATA_W-1:0]    core_sine,
  input  logic signed [DATA_W-1:0]    core_cosine,
  input  logic                        core_valid
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  arb_state_e               state_q,       state_d;
  logic [IDX_W-1:0]         ptr_q,         ptr_d;
  logic [IDX_W-1:0]         gnt_idx_q,     gnt_idx_d;
  logic [CNT_W-1:0]         cnt_q,         cnt_d;
  logic                     core_vld_prv_q, core_vld_prv_d;
  logic signed [DATA_W-1:0] cap_sine_q,    cap_sine_d;
  logic signed [DATA_W-1:0] cap_cos_q,     cap_cos_d;
  logic                     cap_to_q,      cap_to_d;
  logic [NUM_REQ-1:0]       req_ready_q,   req_ready_d;
  logic                     rsp_valid_q,   rsp_valid_d;
  logic [IDX_W-1:0]         rsp_id_q,      rsp_id_d;
  logic signed [DATA_W-1:0] rsp_sine_q,    rsp_sine_d;
  logic signed [DATA_W-1:0] rsp_cos_q,     rsp_cos_d;
  logic                     rsp_to_q,      rsp_to_d;
  logic                     busy_q,        busy_d;
  logic                     core_en_q,     core_en_d;
  logic                     core_start_q,  core_start_d;
  logic [ANGLE_W-1:0]       core_angle_q,  core_angle_d;

  logic [NUM_REQ-1:0]       grant_s;
  logic [IDX_W-1:0]         grant_idx_s;
  logic                     grant_any_s;
  logic [ANGLE_W-1:0]       angle_sel_s;
  logic                     core_edge_s;
  logic [CNT_W-1:0]         cnt_inc_s;

  rr_arbiter #(
    .N (NUM_REQ)
  ) u_rr (
    .req       (req_valid),
    .ptr       (ptr_q),
    .grant     (grant_s),
    .grant_idx (grant_idx_s),
    .grant_any (grant_any_s)
  );

  // Angle slice belonging to the requester that would win this cycle.
  always_comb begin
    angle_sel_s = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_s[i]) begin
        angle_sel_s = req_angle[i*ANGLE_W +: ANGLE_W];
      end else begin
        angle_sel_s = angle_sel_s;
      end
    end
  end

  assign core_edge_s = core_valid && !core_vld_prv_q;
  assign cnt_inc_s   = cnt_q + CNT_W'(1);

  // Next-state and registered-output computation. Each state's outputs
  // become visible in the cycle after the state itself.
  always_comb begin
    state_d        = state_q;
    ptr_d          = ptr_q;
    gnt_idx_d      = gnt_idx_q;
    cnt_d          = cnt_q;
    core_vld_prv_d = core_valid;
    cap_sine_d     = cap_sine_q;
    cap_cos_d      = cap_cos_q;
    cap_to_d       = cap_to_q;
    req_ready_d    = '0;
    rsp_valid_d    = 1'b0;
    rsp_id_d       = rsp_id_q;
    rsp_sine_d     = rsp_sine_q;
    rsp_cos_d      = rsp_cos_q;
    rsp_to_d       = rsp_to_q;
    core_en_d      = 1'b1;
    core_start_d   = 1'b0;
    core_angle_d   = core_angle_q;

    case (state_q)
      IDLE: begin
        if (en && grant_any_s) begin
          req_ready_d  = grant_s;
          gnt_idx_d    = grant_idx_s;
          core_angle_d = angle_sel_s;
          state_d      = ISSUE;
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        core_start_d = 1'b1;
        cnt_d        = '0;
        state_d      = WAIT;
      end
      WAIT: begin
        // A result edge wins over a timeout landing in the same cycle.
        if (core_edge_s) begin
          cap_sine_d = core_sine;
          cap_cos_d  = core_cosine;
          cap_to_d   = 1'b0;
          state_d    = RESP;
        end else if (cnt_inc_s == CNT_W'(TIMEOUT - 1)) begin
          cap_sine_d = '0;
          cap_cos_d  = '0;
          cap_to_d   = 1'b1;
          state_d    = RESP;
        end else begin
          cnt_d = cnt_inc_s;
        end
      end
      RESP: begin
        rsp_valid_d = 1'b1;
        rsp_id_d    = gnt_idx_q;
        rsp_sine_d  = cap_sine_q;
        rsp_cos_d   = cap_cos_q;
        rsp_to_d    = cap_to_q;
        ptr_d       = next_ptr(gnt_idx_q, NUM_REQ);
        state_d     = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      ptr_q          <= '0;
      gnt_idx_q      <= '0;
      cnt_q          <= '0;
      core_vld_prv_q <= 1'b0;
      cap_sine_q     <= '0;
      cap_cos_q      <= '0;
      cap_to_q       <= 1'b0;
      req_ready_q    <= '0;
      rsp_valid_q    <= 1'b0;
      rsp_id_q       <= '0;
      rsp_sine_q     <= '0;
      rsp_cos_q      <= '0;
      rsp_to_q       <= 1'b0;
      busy_q         <= 1'b0;
      core_en_q      <= 1'b0;
      core_start_q   <= 1'b0;
      core_angle_q   <= '0;
    end else begin
      state_q        <= state_d;
      ptr_q          <= ptr_d;
      gnt_idx_q      <= gnt_idx_d;
      cnt_q          <= cnt_d;
      core_vld_prv_q <= core_vld_prv_d;
      cap_sine_q     <= cap_sine_d;
      cap_cos_q      <= cap_cos_d;
      cap_to_q       <= cap_to_d;
      req_ready_q    <= req_ready_d;
      rsp_valid_q    <= rsp_valid_d;
      rsp_id_q       <= rsp_id_d;
      rsp_sine_q     <= rsp_sine_d;
      rsp_cos_q      <= rsp_cos_d;
      rsp_to_q       <= rsp_to_d;
      busy_q         <= busy_d;
      core_en_q      <= core_en_d;
      core_start_q   <= core_start_d;
      core_angle_q   <= core_angle_d;
    end
  end

  assign req_ready   = req_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_id      = rsp_id_q;
  assign rsp_sine    = rsp_sine_q;
  assign rsp_cosine  = rsp_cos_q;
  assign rsp_timeout = rsp_to_q;
  assign busy        = busy_q;
  assign core_enable = core_en_q;
  assign core_start  = core_start_q;
  assign core_angle  = core_angle_q;

endmodule
